// File: rtl/raster_scan_gen.sv
// Raster timing generator and pixel sequencer.
// Drives the sprite query, registers the pixel/sync stream, double-buffers sprite position.
module raster_scan_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CX_INIT  = 320,
  parameter int CY_INIT  = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pos_wr,
  input  logic [10:0] cx_wr,
  input  logic [10:0] cy_wr,
  input  logic        hit,
  output logic [10:0] px,
  output logic [10:0] py,
  output logic [10:0] cx,
  output logic [10:0] cy,
  output logic        pos_pending,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pix,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] CX_RST = 11'(CX_INIT);
  localparam logic [10:0] CY_RST = 11'(CY_INIT);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pos_state_t;

  pos_state_t  state;
  pos_state_t  state_nx;
  logic [10:0] shadow_x;
  logic [10:0] shadow_y;
  logic        act;
  logic        hs_c;
  logic        vs_c;
  logic        h_wrap;
  logic        commit;

  assign h_wrap = (px == H_LAST);
  assign commit = en && h_wrap && (py == V_LAST);
  assign act    = (px < H_ACT) && (py < V_ACT);
  assign hs_c   = (px >= HS_BEG) && (px <= HS_END);
  assign vs_c   = (py >= VS_BEG) && (py <= VS_END);

  assign pos_pending = (state == PENDING);

  // Pixel and line counters, advancing on the pixel-clock enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px <= '0;
      py <= '0;
    end else if (en) begin
      if (h_wrap) begin
        px <= '0;
        py <= (py == V_LAST) ? 11'd0 : py + 11'd1;
      end else begin
        px <= px + 11'd1;
      end
    end
  end

  // One-stage output pipeline aligned to the counter values it was built from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de          <= 1'b0;
      pix         <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else if (en) begin
      de          <= act;
      pix         <= act & hit;
      hsync       <= hs_c ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_c ? SYNC_POL : ~SYNC_POL;
      frame_start <= (px == '0) && (py == '0);
    end
  end

  // Shadow position captures host writes at any time, independent of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_x <= CX_RST;
      shadow_y <= CY_RST;
    end else if (pos_wr) begin
      shadow_x <= cx_wr;
      shadow_y <= cy_wr;
    end
  end

  // Committed position only moves at end of frame, so no tearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx <= CX_RST;
      cy <= CY_RST;
    end else if (commit && (state == PENDING)) begin
      cx <= shadow_x;
      cy <= shadow_y;
    end
  end

  // Position buffer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A write arriving on the commit cycle keeps the buffer pending.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pos_wr) state_nx = PENDING;
      end
      PENDING: begin
        if (commit && !pos_wr) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_raster_scan_gen.sv
// Randomized bench for raster_scan_gen.
// Reference model derives timing from a frame-position count.
module tb_raster_scan_gen;

  localparam int HA  = 16;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 2;
  localparam int VA  = 6;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 1;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int FT  = HT * VT;
  localparam int CXI = 5;
  localparam int CYI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pos_wr;
  logic [10:0] cx_wr;
  logic [10:0] cy_wr;
  logic        hit;
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] cx;
  logic [10:0] cy;
  logic        pos_pending;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        pix;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  int t;
  bit m_de, m_pix, m_hs, m_vs, m_fs, m_pend;
  int m_cx, m_cy, m_sx, m_sy;

  raster_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CX_INIT(CXI), .CY_INIT(CYI)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pos_wr(pos_wr), .cx_wr(cx_wr), .cy_wr(cy_wr),
    .hit(hit), .px(px), .py(py), .cx(cx), .cy(cy),
    .pos_pending(pos_pending), .hsync(hsync), .vsync(vsync),
    .de(de), .pix(pix), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_de = 0; m_pix = 0; m_fs = 0;
    m_hs = 1; m_vs = 1;
    m_cx = CXI; m_cy = CYI;
    m_sx = CXI; m_sy = CYI;
    m_pend = 0;
  endtask

  task automatic check_all();
    check("px", 32'(px), t % HT);
    check("py", 32'(py), t / HT);
    check("de", 32'(de), 32'(m_de));
    check("pix", 32'(pix), 32'(m_pix));
    check("hsync", 32'(hsync), 32'(m_hs));
    check("vsync", 32'(vsync), 32'(m_vs));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("cx", 32'(cx), m_cx);
    check("cy", 32'(cy), m_cy);
    check("pos_pending", 32'(pos_pending), 32'(m_pend));
  endtask

  // Advance the model by what the coming rising edge will do.
  task automatic model_step();
    int  x, y;
    bit  a;
    if (en) begin
      x = t % HT;
      y = t / HT;
      a = (x < HA) && (y < VA);
      m_de  = a;
      m_pix = a && hit;
      m_hs  = !((x >= HA + HF) && (x < HA + HF + HS));
      m_vs  = !((y >= VA + VF) && (y < VA + VF + VS));
      m_fs  = (t == 0);
      if (t == FT - 1 && m_pend) begin
        m_cx = m_sx;
        m_cy = m_sy;
        m_pend = 0;
      end
      t = (t + 1) % FT;
    end
    if (pos_wr) begin
      m_sx = cx_wr;
      m_sy = cy_wr;
      m_pend = 1;
    end
  endtask

  // mode 0: en=1, random hit; 1: random en/pos_wr; 2: hit=1;
  // 3: hit only outside active columns; 4: directed commit writes;
  // 5: en toggling every cycle with sparse writes.
  task automatic run(input int mode, input int n);
    bit done_a = 0;
    bit done_b = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
      en     = 1'b1;
      hit    = 1'($urandom_range(0, 1));
      pos_wr = 1'b0;
      cx_wr  = 11'($urandom_range(0, 2047));
      cy_wr  = 11'($urandom_range(0, 2047));
      case (mode)
        1: begin
          en     = 1'($urandom_range(0, 1));
          pos_wr = ($urandom_range(0, 15) == 0);
        end
        2: hit = 1'b1;
        3: hit = ((t % HT) >= HA);
        4: begin
          if (!done_a && t == 40) begin
            pos_wr = 1'b1; cx_wr = 11'd100; cy_wr = 11'd50;
            done_a = 1;
          end else if (done_a && !done_b && t == FT - 1) begin
            pos_wr = 1'b1; cx_wr = 11'd200; cy_wr = 11'd200;
            done_b = 1;
          end
        end
        5: begin
          en     = i[0];
          pos_wr = ($urandom_range(0, 31) == 0);
        end
        default: ;
      endcase
      model_step();
    end
  endtask

  task automatic reset_mid_frame();
    bit found = 0;
    for (int i = 0; i < 4 * FT; i++) begin
      @(negedge clk);
      check_all();
      if (t == 3 * HT + 10) begin
        found = 1;
        break;
      end
      en     = i[0];
      hit    = 1'($urandom_range(0, 1));
      pos_wr = ($urandom_range(0, 7) == 0);
      cx_wr  = 11'($urandom_range(0, 2047));
      cy_wr  = 11'($urandom_range(0, 2047));
      model_step();
    end
    check("reset_point_reached", 32'(found), 32'd1);
    pos_wr = 1'b1;
    cx_wr  = 11'd77;
    cy_wr  = 11'd66;
    rst    = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    en     = 1'b0;
    pos_wr = 1'b0;
    rst    = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    pos_wr = 1'b0;
    cx_wr  = '0;
    cy_wr  = '0;
    hit    = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    run(0, 2 * FT);
    run(2, FT);
    run(3, FT);
    run(4, 3 * FT);
    run(1, 4 * FT);
    reset_mid_frame();
    run(5, 2 * FT);
    run(1, 2 * FT);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
